// File: rtl/glyph_fetch_scheduler_if.sv
// rtl/glyph_fetch_scheduler_if.sv - shared glyph memory read port (req/ack, text RAM or font ROM)
interface glyph_fetch_scheduler_if #(
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req, mem_sel, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_sel, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/glyph_fetch_scheduler.sv
// rtl/glyph_fetch_scheduler.sv - one-cell-ahead char/glyph fetch and pixel serializer for 8x16 text mode
module glyph_fetch_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int COLS     = 80,
  parameter int ADDR_W   = 12
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [9:0]                    i_hpos,
  input  logic [9:0]                    i_vpos,
  glyph_fetch_scheduler_if.master       mem,
  input  logic                          i_underrun_clr,
  output logic                          o_pixel,
  output logic                          o_underrun
);

  localparam logic [9:0] HA         = 10'(H_ACTIVE);
  localparam logic [9:0] HT_M1      = 10'(H_TOTAL - 1);
  localparam logic [9:0] HT_M8      = 10'(H_TOTAL - 8);
  localparam logic [9:0] VA         = 10'(V_ACTIVE);
  localparam logic [9:0] VT_M1      = 10'(V_TOTAL - 1);
  localparam logic [9:0] LAST_START = 10'(H_ACTIVE - 16);
  localparam logic [9:0] LAST_LOAD  = 10'(H_ACTIVE - 9);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  typedef enum logic [2:0] {S_IDLE, S_TXT, S_FONT, S_READY, S_DRAIN} state_t;

  state_t            r_state, w_state_n;
  logic              r_sel, w_sel_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [3:0]        r_lrow, w_lrow_n;
  logic [7:0]        r_row, w_row_n;
  logic [7:0]        r_shift, w_shift_n;
  logic              r_underrun, w_underrun_n;
  logic              r_pend, w_pend_n;
  logic [6:0]        r_pend_col, w_pend_col_n;
  logic [9:0]        r_pend_line, w_pend_line_n;

  logic [9:0] w_line;
  logic       w_line_ok;
  logic       w_start;
  logic       w_load;
  logic [6:0] w_start_col;
  logic [6:0] w_load_col;
  logic       w_ack;
  logic       w_pend_stale;

  function automatic logic [ADDR_W-1:0] f_text_addr(input logic [9:0] line, input logic [6:0] col);
    return ADDR_W'(line[9:4]) * COLS_A + ADDR_W'(col);
  endfunction

  // Past the visible area the next cell to fetch is column 0 of the following line.
  assign w_line      = (i_hpos < HA) ? i_vpos : ((i_vpos == VT_M1) ? 10'd0 : i_vpos + 10'd1);
  assign w_line_ok   = (w_line < VA);
  assign w_start_col = (i_hpos == HT_M8) ? 7'd0 : i_hpos[9:3] + 7'd1;
  assign w_load_col  = (i_hpos == HT_M1) ? 7'd0 : i_hpos[9:3] + 7'd1;
  assign w_start     = w_line_ok && (((i_hpos[2:0] == 3'd0) && (i_hpos <= LAST_START)) || (i_hpos == HT_M8));
  assign w_load      = w_line_ok && (((i_hpos[2:0] == 3'd7) && (i_hpos <= LAST_LOAD)) || (i_hpos == HT_M1));
  assign w_ack       = mem.mem_ack & mem.mem_req;
  assign w_pend_stale = w_load && (r_pend_col == w_load_col);

  assign mem.mem_req  = (r_state == S_TXT) || (r_state == S_FONT) || (r_state == S_DRAIN);
  assign mem.mem_sel  = r_sel;
  assign mem.mem_addr = r_addr;
  assign o_pixel      = r_shift[7] & (i_hpos < HA) & (i_vpos < VA);
  assign o_underrun   = r_underrun;

  always_comb begin
    w_state_n     = r_state;
    w_sel_n       = r_sel;
    w_addr_n      = r_addr;
    w_lrow_n      = r_lrow;
    w_row_n       = r_row;
    w_shift_n     = {r_shift[6:0], 1'b0};
    w_underrun_n  = r_underrun & ~i_underrun_clr;
    w_pend_n      = r_pend;
    w_pend_col_n  = r_pend_col;
    w_pend_line_n = r_pend_line;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_n = S_TXT;
          w_sel_n   = 1'b0;
          w_addr_n  = f_text_addr(w_line, w_start_col);
          w_lrow_n  = w_line[3:0];
          w_pend_n  = 1'b0;
        end else if (r_pend && !w_pend_stale) begin
          w_state_n = S_TXT;
          w_sel_n   = 1'b0;
          w_addr_n  = f_text_addr(r_pend_line, r_pend_col);
          w_lrow_n  = r_pend_line[3:0];
          w_pend_n  = 1'b0;
        end
      end
      S_TXT: begin
        if (w_ack) begin
          w_state_n = S_FONT;
          w_sel_n   = 1'b1;
          w_addr_n  = ADDR_W'({mem.mem_rdata, r_lrow});
        end
      end
      S_FONT: begin
        if (w_ack) begin
          w_state_n = S_READY;
          w_row_n   = mem.mem_rdata;
        end
      end
      S_READY: ;
      S_DRAIN: begin
        if (w_ack) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_start && (r_state != S_IDLE)) begin
      w_pend_n      = 1'b1;
      w_pend_col_n  = w_start_col;
      w_pend_line_n = w_line;
    end

    // A late cell shows blank; its in-flight read must still finish before the port is reused.
    if (w_load) begin
      if (w_pend_stale) w_pend_n = 1'b0;
      if (r_state == S_READY) begin
        w_shift_n = r_row;
        w_state_n = S_IDLE;
      end else begin
        w_shift_n    = 8'h00;
        w_underrun_n = 1'b1;
        if ((r_state == S_TXT) || (r_state == S_FONT)) w_state_n = w_ack ? S_IDLE : S_DRAIN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_lrow      <= 4'd0;
      r_row       <= 8'h00;
      r_shift     <= 8'h00;
      r_underrun  <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_col  <= 7'd0;
      r_pend_line <= 10'd0;
    end else begin
      r_state     <= w_state_n;
      r_sel       <= w_sel_n;
      r_addr      <= w_addr_n;
      r_lrow      <= w_lrow_n;
      r_row       <= w_row_n;
      r_shift     <= w_shift_n;
      r_underrun  <= w_underrun_n;
      r_pend      <= w_pend_n;
      r_pend_col  <= w_pend_col_n;
      r_pend_line <= w_pend_line_n;
    end
  end

endmodule

// File: tb/tb_glyph_fetch_scheduler.sv
// tb/tb_glyph_fetch_scheduler.sv - directed self-checking bench for glyph_fetch_scheduler
module tb_glyph_fetch_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos_s, vpos_s;
  logic       underrun_clr;
  logic       pixel, underrun;

  always #5 clk = ~clk;

  glyph_fetch_scheduler_if #(.ADDR_W(12)) mem_if ();

  glyph_fetch_scheduler dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_hpos         (hpos_s),
    .i_vpos         (vpos_s),
    .mem            (mem_if),
    .i_underrun_clr (underrun_clr),
    .o_pixel        (pixel),
    .o_underrun     (underrun)
  );

  typedef struct {
    string      name;
    int         line;
    int         col;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [11:0] addr;
  } txn_t;

  vec_t       vecs[16];
  txn_t       log_q[$];
  logic [7:0] cell_cap[0:479][0:79];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   bh, bv;
  int   req_cnt, txt_delay, font_delay, sp_addr, sp_delay;
  logic sp_sel;
  bit   cap_en, req_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] txn_at(input int i);
    if (i >= log_q.size()) return 32'hFFFF_FFFF;
    return {19'd0, log_q[i].sel, log_q[i].addr};
  endfunction

  // One pixel clock: beam advances like hvsync, then the memory model answers.
  task automatic step();
    int d;
    @(posedge clk);
    #1;
    bh++;
    if (bh == 800) begin
      bh = 0;
      bv = (bv == 524) ? 0 : bv + 1;
    end
    hpos_s = 10'(bh);
    vpos_s = 10'(bv);
    #1;
    if (cap_en && bh < 640 && bv < 480) cell_cap[bv][bh / 8][7 - (bh % 8)] = pixel;
    mem_if.mem_ack = 1'b0;
    if (mem_if.mem_req) begin
      req_seen = 1'b1;
      d = mem_if.mem_sel ? font_delay : txt_delay;
      if (mem_if.mem_sel == sp_sel && int'(mem_if.mem_addr) == sp_addr) d = sp_delay;
      if (req_cnt >= d) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = mem_if.mem_sel ? mem_if.mem_addr[11:4] : mem_if.mem_addr[7:0];
        log_q.push_back('{sel: mem_if.mem_sel, addr: mem_if.mem_addr});
        req_cnt = 0;
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_beam(input int v, input int h);
    bv = v;
    bh = h;
    hpos_s = 10'(h);
    vpos_s = 10'(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    req_cnt = 0;
    req_seen = 1'b0;
    sp_addr = -1;
    log_q.delete();
  endtask

  initial begin
    int bad;
    vecs[0]  = '{"l0_c0",  0, 0,  8'h00};
    vecs[1]  = '{"l0_c1",  0, 1,  8'h01};
    vecs[2]  = '{"l0_c2",  0, 2,  8'h02};
    vecs[3]  = '{"l0_c7",  0, 7,  8'h07};
    vecs[4]  = '{"l0_c10", 0, 10, 8'h0A};
    vecs[5]  = '{"l0_c37", 0, 37, 8'h25};
    vecs[6]  = '{"l0_c64", 0, 64, 8'h40};
    vecs[7]  = '{"l0_c78", 0, 78, 8'h4E};
    vecs[8]  = '{"l0_c79", 0, 79, 8'h4F};
    vecs[9]  = '{"l2_c9",  2, 9,  8'h09};
    vecs[10] = '{"l2_c10_blank", 2, 10, 8'h00};
    vecs[11] = '{"l2_c11", 2, 11, 8'h0B};
    vecs[12] = '{"l2_c12", 2, 12, 8'h0C};
    vecs[13] = '{"l4_c5_blank", 4, 5, 8'h00};
    vecs[14] = '{"l4_c6",  4, 6,  8'h06};
    vecs[15] = '{"l4_c7",  4, 7,  8'h07};

    reset = 1'b1;
    underrun_clr = 1'b0;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 8'h00;
    txt_delay = 0;
    font_delay = 0;
    sp_sel = 1'b0;
    sp_addr = -1;
    sp_delay = 0;
    cap_en = 1'b0;
    set_beam(0, 0);

    do_reset();
    check("rst_req", 32'(mem_if.mem_req), 0);
    check("rst_sel", 32'(mem_if.mem_sel), 0);
    check("rst_addr", 32'(mem_if.mem_addr), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_underrun", 32'(underrun), 0);

    // zero-wait memory across line 0, column 0 fetched at the frame wrap
    cap_en = 1'b1;
    set_beam(524, 780);
    run(660);
    check("l0_txn_count", 32'(log_q.size()), 160);
    check("wrap_txt_addr", txn_at(0), {19'd0, 1'b0, 12'd0});
    check("wrap_font_addr", txn_at(1), {19'd0, 1'b1, 12'd0});
    check("c1_font_addr", txn_at(3), {19'd0, 1'b1, 12'd16});
    check("l0_underrun", 32'(underrun), 0);

    do_reset();
    set_beam(37, 32);
    run(12);
    check("v37_txt_addr", txn_at(0), {19'd0, 1'b0, 12'd165});
    check("v37_font_addr", txn_at(1), {19'd0, 1'b1, 12'd2645});
    check("v37_underrun", 32'(underrun), 0);

    // late text read for column 10 of line 2
    do_reset();
    sp_sel = 1'b0;
    sp_addr = 10;
    sp_delay = 7;
    set_beam(1, 780);
    run(660);
    check("late_underrun_set", 32'(underrun), 1);
    sp_addr = -1;
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 0);
    step();
    check("underrun_stays_clear", 32'(underrun), 0);

    do_reset();
    set_beam(479, 785);
    req_seen = 1'b0;
    run(25);
    check("vblank_no_req", 32'(req_seen), 0);
    check("vblank_no_underrun", 32'(underrun), 0);

    // reset while the font read for column 3 of line 3 is stalled
    do_reset();
    sp_sel = 1'b1;
    sp_addr = 51;
    sp_delay = 50;
    set_beam(3, 8);
    run(13);
    check("midfont_req", {29'd0, mem_if.mem_req, mem_if.mem_sel, 1'b0}, 32'h6);
    check("midfont_addr", 32'(mem_if.mem_addr), 51);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sp_addr = -1;
    check("post_rst_req", 32'(mem_if.mem_req), 0);
    check("post_rst_pixel", 32'(pixel), 0);
    set_beam(3, 700);
    req_seen = 1'b0;
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 8'hFF;
    run(5);
    check("stray_ack_no_req", 32'(req_seen), 0);
    check("stray_ack_addr", 32'(mem_if.mem_addr), 0);
    check("stray_ack_underrun", 32'(underrun), 0);

    // text read for column 3 of line 4 held off 20 cycles
    do_reset();
    sp_sel = 1'b0;
    sp_addr = 3;
    sp_delay = 20;
    set_beam(4, 16);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(mem_if.mem_req === 1'b1 && mem_if.mem_sel === 1'b0 && mem_if.mem_addr === 12'd3)) bad++;
    end
    check("hold_stable_cycles", 32'(bad), 0);
    run(28);
    check("hold_underrun", 32'(underrun), 1);
    check("hold_txn0", txn_at(0), {19'd0, 1'b0, 12'd3});
    check("pending_served", txn_at(1), {19'd0, 1'b0, 12'd5});
    check("next_txt", txn_at(2), {19'd0, 1'b0, 12'd6});
    check("next_font", txn_at(3), {19'd0, 1'b1, 12'd100});

    for (int i = 0; i < 16; i++) begin
      check(vecs[i].name, 32'(cell_cap[vecs[i].line][vecs[i].col]), 32'(vecs[i].exp));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
